rgb2raw_bayer_tx: RTL and testbench

//  Re-mosaics an RGB pixel stream into 12-bit Bayer RAW and transmits it with D8M-style FVAL/LVAL framing.

---
 rtl/rgb2raw_pkg.sv | 37 +++
 rtl/rgb2raw_bayer_tx_if.sv | 26 ++
 rtl/bayer_frame_timer.sv | 108 ++++++++++
 rtl/rgb2raw_bayer_tx.sv | 113 +++++++++++
 tb/tb_rgb2raw_bayer_tx.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/rgb2raw_pkg.sv
// Shared types for the RGB-to-Bayer transmitter: FSM states, CFA colour codes and the
// colour-bar table used when RGB2RAW_TESTPAT_EN is defined.
package rgb2raw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        LINE,
        HBLANK,
        TRAIL,
        VBLANK
    } txState_t;

    localparam logic [1:0] CFA_G0 = 2'd0;
    localparam logic [1:0] CFA_R  = 2'd1;
    localparam logic [1:0] CFA_B  = 2'd2;
    localparam logic [1:0] CFA_G1 = 2'd3;

    localparam int unsigned NUM_BARS = 8;

    // Returns {R,G,B} on/off for bars white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] barRgb(input logic [2:0] idx);
        logic [2:0] rgb;
        unique case (idx)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/rgb2raw_bayer_tx_if.sv
// Pixel input handshake and D8M-style RAW output bus of the Bayer transmitter.
// master = upstream source / downstream sink side, slave = the transmitter.
interface rgb2raw_bayer_tx_if;

    logic [11:0] iRed;
    logic [11:0] iGreen;
    logic [11:0] iBlue;
    logic        iValid;
    logic        oReady;
    logic [11:0] mCCD_DATA;
    logic        CCD_FVAL;
    logic        CCD_LVAL;
    logic [15:0] X_Cont;
    logic [15:0] Y_Cont;

    modport master (
        output iRed, iGreen, iBlue, iValid,
        input  oReady, mCCD_DATA, CCD_FVAL, CCD_LVAL, X_Cont, Y_Cont
    );

    modport slave (
        input  iRed, iGreen, iBlue, iValid,
        output oReady, mCCD_DATA, CCD_FVAL, CCD_LVAL, X_Cont, Y_Cont
    );

endinterface

// File: rtl/bayer_frame_timer.sv
// Frame timing FSM with horizontal and vertical-blank counters. Exposes the next state and the
// column/row the next cycle will carry, so the top can register its outputs one edge ahead.
module bayer_frame_timer
    import rgb2raw_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_BLANK  = 160,
    parameter int unsigned FV_LEAD  = 8,
    parameter int unsigned V_BLANK  = 45
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output txState_t    nextState,
    output logic [15:0] xNext,
    output logic [15:0] yNext,
    output logic        nextIsLine
);

    localparam logic [15:0] LEAD_LAST = 16'(FV_LEAD - 1);
    localparam logic [15:0] HA_LAST   = 16'(H_ACTIVE - 1);
    localparam logic [15:0] HB_LAST   = 16'(H_BLANK - 1);
    localparam logic [15:0] HT_LAST   = 16'(H_ACTIVE + H_BLANK - 1);
    localparam logic [15:0] VA_LAST   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] VB_LAST   = 16'(V_BLANK - 1);

    txState_t    stateQ, stateD;
    logic [15:0] cntQ, cntD;
    logic [15:0] vcntQ, vcntD;
    logic [15:0] yQ, yD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= IDLE;
            cntQ   <= 16'd0;
            vcntQ  <= 16'd0;
            yQ     <= 16'd0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            vcntQ  <= vcntD;
            yQ     <= yD;
        end
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ + 16'd1;
        vcntD  = vcntQ;
        yD     = yQ;
        unique case (stateQ)
            IDLE: begin
                cntD = 16'd0;
                if (en) stateD = LEAD;
            end
            LEAD: begin
                if (cntQ == LEAD_LAST) begin
                    stateD = LINE;
                    cntD   = 16'd0;
                end
            end
            LINE: begin
                if (cntQ == HA_LAST) begin
                    cntD = 16'd0;
                    // Last line skips HBLANK and wraps the row for the next frame.
                    if (yQ == VA_LAST) begin
                        stateD = TRAIL;
                        yD     = 16'd0;
                    end else begin
                        stateD = HBLANK;
                        yD     = yQ + 16'd1;
                    end
                end
            end
            HBLANK: begin
                if (cntQ == HB_LAST) begin
                    stateD = LINE;
                    cntD   = 16'd0;
                end
            end
            TRAIL: begin
                if (cntQ == LEAD_LAST) begin
                    stateD = VBLANK;
                    cntD   = 16'd0;
                    vcntD  = 16'd0;
                end
            end
            VBLANK: begin
                if (cntQ == HT_LAST) begin
                    cntD = 16'd0;
                    if (vcntQ == VB_LAST) stateD = en ? LEAD : IDLE;
                    else vcntD = vcntQ + 16'd1;
                end
            end
            default: begin
                stateD = IDLE;
                cntD   = 16'd0;
            end
        endcase
    end

    assign nextState  = stateD;
    assign nextIsLine = (stateD == LINE);
    assign xNext      = cntD;
    assign yNext      = yD;

endmodule

// File: rtl/rgb2raw_bayer_tx.sv
// Re-mosaics an RGB stream into 12-bit Bayer RAW with FVAL/LVAL framing.
// Optional colour-bar source enabled by defining RGB2RAW_TESTPAT_EN (adds iTestSel).
module rgb2raw_bayer_tx
    import rgb2raw_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_BLANK     = 160,
    parameter int unsigned FV_LEAD     = 8,
    parameter int unsigned V_BLANK     = 45,
    parameter logic [1:0]  BAYER_PHASE = 2'd0
) (
    input  logic                 CCD_PIXCLK,
    input  logic                 RST,
    input  logic                 iEN,
`ifdef RGB2RAW_TESTPAT_EN
    input  logic                 iTestSel,
`endif
    output logic                 oUnderrun,
    rgb2raw_bayer_tx_if.slave    bus
);

    txState_t    nextState;
    logic [15:0] xNext;
    logic [15:0] yNext;
    logic        nextIsLine;

    bayer_frame_timer #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .FV_LEAD  (FV_LEAD),
        .V_BLANK  (V_BLANK)
    ) u_timer (
        .clk        (CCD_PIXCLK),
        .rst        (RST),
        .en         (iEN),
        .nextState  (nextState),
        .xNext      (xNext),
        .yNext      (yNext),
        .nextIsLine (nextIsLine)
    );

    logic [11:0] red, green, blue, pix;
    logic        valid;
    logic [1:0]  cfa;

`ifdef RGB2RAW_TESTPAT_EN
    localparam logic [15:0] BAR_W = 16'(H_ACTIVE / NUM_BARS);
    logic [2:0] bar;
`endif

    always_comb begin
        red   = bus.iRed;
        green = bus.iGreen;
        blue  = bus.iBlue;
        valid = bus.iValid;
`ifdef RGB2RAW_TESTPAT_EN
        bar = 3'd0;
        if (iTestSel) begin
            bar   = barRgb(3'(xNext / BAR_W));
            red   = {12{bar[2]}};
            green = {12{bar[1]}};
            blue  = {12{bar[0]}};
            valid = 1'b1;
        end
`endif
        cfa = BAYER_PHASE ^ {yNext[0], xNext[0]};
        pix = green;
        unique case (cfa)
            CFA_R:          pix = red;
            CFA_B:          pix = blue;
            CFA_G0, CFA_G1: pix = green;
            default:        pix = green;
        endcase
    end

    logic        fvalQ, lvalQ, underrunQ;
    logic [11:0] dataQ;
    logic [15:0] xQ, yQ;

    // Outputs are registered from the timer's next-state view so they line up with its state.
    always_ff @(posedge CCD_PIXCLK or posedge RST) begin
        if (RST) begin
            fvalQ     <= 1'b0;
            lvalQ     <= 1'b0;
            dataQ     <= 12'h000;
            xQ        <= 16'd0;
            yQ        <= 16'd0;
            underrunQ <= 1'b0;
        end else begin
            fvalQ <= (nextState != IDLE) && (nextState != VBLANK);
            lvalQ <= nextIsLine;
            dataQ <= (nextIsLine && valid) ? pix : 12'h000;
            xQ    <= nextIsLine ? xNext : 16'd0;
            yQ    <= yNext;
            if ((nextState == LEAD) && !fvalQ) begin
                underrunQ <= 1'b0;
            end else if (nextIsLine && !valid) begin
                underrunQ <= 1'b1;
            end
        end
    end

    assign bus.oReady    = nextIsLine;
    assign bus.mCCD_DATA = dataQ;
    assign bus.CCD_FVAL  = fvalQ;
    assign bus.CCD_LVAL  = lvalQ;
    assign bus.X_Cont    = xQ;
    assign bus.Y_Cont    = yQ;
    assign oUnderrun     = underrunQ;

endmodule

// File: tb/tb_rgb2raw_bayer_tx.sv
// Bench for rgb2raw_bayer_tx: random RGB stream, frame-arithmetic reference model, two Bayer phases.
module tb_rgb2raw_bayer_tx;

    localparam int HA  = 8;
    localparam int VA  = 4;
    localparam int HB  = 4;
    localparam int FVL = 2;
    localparam int VB  = 2;
    localparam int HT  = HA + HB;
    localparam int ACT = VA * HA + (VA - 1) * HB;
    localparam int P   = 2 * FVL + ACT + VB * HT;

    logic clk = 1'b0;
    logic RST = 1'b0;
    logic iEN = 1'b0;
    logic undA, undB;

    rgb2raw_bayer_tx_if busA ();
    rgb2raw_bayer_tx_if busB ();

    rgb2raw_bayer_tx #(
        .H_ACTIVE (HA), .V_ACTIVE (VA), .H_BLANK (HB), .FV_LEAD (FVL), .V_BLANK (VB),
        .BAYER_PHASE (2'd0)
    ) dutA (
        .CCD_PIXCLK (clk),
        .RST        (RST),
        .iEN        (iEN),
`ifdef RGB2RAW_TESTPAT_EN
        .iTestSel   (1'b0),
`endif
        .oUnderrun  (undA),
        .bus        (busA)
    );

    rgb2raw_bayer_tx #(
        .H_ACTIVE (HA), .V_ACTIVE (VA), .H_BLANK (HB), .FV_LEAD (FVL), .V_BLANK (VB),
        .BAYER_PHASE (2'd1)
    ) dutB (
        .CCD_PIXCLK (clk),
        .RST        (RST),
        .iEN        (iEN),
`ifdef RGB2RAW_TESTPAT_EN
        .iTestSel   (1'b0),
`endif
        .oUnderrun  (undB),
        .bus        (busB)
    );

    always #5 clk = ~clk;

    int nCmp = 0;
    int nErr = 0;
    int t, lastFrame, dropT, enOffT, accepted;
    bit expUnder;
    bit pV;
    logic [11:0] pR, pG, pB;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    // Frame-relative arithmetic: lead, VA lines of HA separated by HB (none after the last),
    // trail, then VB blank lines. Frames after lastFrame are idle.
    function automatic void model(input int tt, output bit f, output bit l,
                                  output int x, output int y);
        int tf, u;
        f = 0; l = 0; x = 0; y = 0;
        if (tt / P > lastFrame) return;
        tf = tt % P;
        if (tf < FVL) begin
            f = 1;
        end else if (tf < FVL + ACT) begin
            f = 1;
            u = tf - FVL;
            if (u % HT < HA) begin
                l = 1;
                x = u % HT;
                y = u / HT;
            end else begin
                y = u / HT + 1;
            end
        end else if (tf < 2 * FVL + ACT) begin
            f = 1;
        end
    endfunction

    function automatic logic [11:0] pick(input int phase, input int x, input int y,
                                         input logic [11:0] r, input logic [11:0] g,
                                         input logic [11:0] b);
        int code;
        code = phase ^ ((y % 2) * 2 + (x % 2));
        if (code == 1) return r;
        if (code == 2) return b;
        return g;
    endfunction

    task automatic drive(input bit v);
        pR = 12'($urandom);
        pG = 12'($urandom);
        pB = 12'($urandom);
        pV = v;
        busA.iRed = pR; busA.iGreen = pG; busA.iBlue = pB; busA.iValid = pV;
        busB.iRed = pR; busB.iGreen = pG; busB.iBlue = pB; busB.iValid = pV;
    endtask

    task automatic runCycles(input int n);
        bit eF, eL, nF, nL, v;
        int eX, eY, nX, nY;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            model(t, eF, eL, eX, eY);
            if ((t % P == 0) && (t / P <= lastFrame)) expUnder = 0;
            if (eL && !pV) expUnder = 1;
            chk("fval", 32'(busA.CCD_FVAL), 32'(eF));
            chk("lval", 32'(busA.CCD_LVAL), 32'(eL));
            chk("xcont", 32'(busA.X_Cont), 32'(eX));
            chk("ycont", 32'(busA.Y_Cont), 32'(eY));
            chk("underrun", 32'(undA), 32'(expUnder));
            if (eL) begin
                chk("dataA", 32'(busA.mCCD_DATA), 32'(pV ? pick(0, eX, eY, pR, pG, pB) : 12'h0));
                chk("dataB", 32'(busB.mCCD_DATA), 32'(pV ? pick(1, eX, eY, pR, pG, pB) : 12'h0));
            end
            model(t + 1, nF, nL, nX, nY);
            chk("readyA", 32'(busA.oReady), 32'(nL));
            chk("readyB", 32'(busB.oReady), 32'(nL));
            if (t + 1 == enOffT) iEN = 1'b0;
            v = nL ? (t + 1 != dropT) : 1'($urandom_range(0, 1));
            drive(v);
            if (busA.oReady && pV) accepted++;
            t++;
        end
    endtask

    initial begin
        lastFrame = 1000;
        dropT     = -1;
        enOffT    = -1;
        expUnder  = 0;
        drive(1'b1);
        #1 RST = 1'b1;
        #2;
        chk("rst_fval", 32'(busA.CCD_FVAL), 32'd0);
        chk("rst_lval", 32'(busA.CCD_LVAL), 32'd0);
        chk("rst_data", 32'(busA.mCCD_DATA), 32'd0);
        chk("rst_x", 32'(busA.X_Cont), 32'd0);
        chk("rst_y", 32'(busA.Y_Cont), 32'd0);
        chk("rst_under", 32'(undA), 32'd0);
        chk("rst_ready", 32'(busA.oReady), 32'd0);

        // Frame 0 fully valid; frame 1 starves x=2 of line 1; iEN drops during line 2 of frame 2.
        repeat (2) @(negedge clk);
        RST = 1'b0;
        iEN = 1'b1;
        t   = 0;
        chk("ready_idle", 32'(busA.oReady), 32'd0);
        dropT     = P + FVL + HT + 2;
        enOffT    = 2 * P + FVL + 2 * HT + 3;
        lastFrame = enOffT / P;
        accepted  = 0;
        runCycles(P);
        chk("accepted", 32'(accepted), 32'(HA * VA));
        runCycles(3 * P);

        // Restart from IDLE, then reset in the middle of line 1.
        iEN       = 1'b1;
        t         = 0;
        lastFrame = 1000;
        dropT     = -1;
        enOffT    = -1;
        runCycles(FVL + HT + 3);
        RST = 1'b1;
        #1;
        chk("arst_fval", 32'(busA.CCD_FVAL), 32'd0);
        chk("arst_lval", 32'(busA.CCD_LVAL), 32'd0);
        chk("arst_data", 32'(busA.mCCD_DATA), 32'd0);
        chk("arst_ready", 32'(busA.oReady), 32'd0);
        chk("arst_x", 32'(busA.X_Cont), 32'd0);
        @(negedge clk);
        RST      = 1'b0;
        t        = 0;
        expUnder = 0;
        chk("ready_restart", 32'(busA.oReady), 32'd0);
        runCycles(P + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
